adder57_rr_scheduler: RTL and testbench

ADDER57_RR_SCHEDULER -- requirements
Module: adder57_rr_scheduler

---
 rtl/adder57_rr_scheduler.sv | 93 +++++++++
 tb/tb_adder57_rr_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder57_rr_scheduler.sv
// Round-robin shared 57-bit adder: four requesters, one registered
// WIDTH+1-bit sum per grant, held until downstream accepts it.
module adder57_rr_scheduler #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 57
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]       req_ready,
   output logic                  res_valid,
   output logic [WIDTH:0]        res_sum,
   output logic [1:0]            res_id,
   input  logic                  res_ready,
   output logic                  busy,
   output logic [15:0]           op_count
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t             state;
   logic [1:0]         rr_ptr;
   logic [1:0]         cur_id;
   logic [1:0]         gnt_id;
   logic [1:0]         idx;
   logic               gnt_any;
   logic [NREQ-1:0]    gnt;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;

   // first pending requester at or above rr_ptr, wrapping
   always_comb begin
      gnt     = '0;
      gnt_id  = '0;
      gnt_any = 1'b0;
      idx     = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = rr_ptr + 2'(k);
         if (!gnt_any && req_valid[idx]) begin
            gnt[idx] = 1'b1;
            gnt_id   = idx;
            gnt_any  = 1'b1;
         end
      end
   end

   assign req_ready = (rst_n && state == IDLE) ? gnt : '0;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         cur_id    <= '0;
         op_a      <= '0;
         op_b      <= '0;
         res_valid <= 1'b0;
         res_sum   <= '0;
         res_id    <= '0;
         op_count  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (gnt_any) begin
                  op_a   <= req_a[gnt_id*WIDTH +: WIDTH];
                  op_b   <= req_b[gnt_id*WIDTH +: WIDTH];
                  cur_id <= gnt_id;
                  state  <= CALC;
               end
            end
            CALC: begin
               res_sum   <= {1'b0, op_a} + {1'b0, op_b};
               res_id    <= cur_id;
               res_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  if (op_count != 16'hFFFF)
                     op_count <= op_count + 16'd1;
                  rr_ptr <= res_id + 2'd1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adder57_rr_scheduler.sv
// Directed bench for adder57_rr_scheduler: vector table of single
// operations plus round-robin, backpressure and mid-operation reset.
module tb_adder57_rr_scheduler;

   localparam int W = 57;
   localparam logic [W-1:0] ONES = {W{1'b1}};

   logic           clk = 1'b0;
   logic           rst_n;
   logic [3:0]     req_valid;
   logic [4*W-1:0] req_a;
   logic [4*W-1:0] req_b;
   logic [3:0]     req_ready;
   logic           res_valid;
   logic [W:0]     res_sum;
   logic [1:0]     res_id;
   logic           res_ready;
   logic           busy;
   logic [15:0]    op_count;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_cnt  = 0;

   adder57_rr_scheduler dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .res_valid(res_valid),
      .res_sum(res_sum), .res_id(res_id), .res_ready(res_ready),
      .busy(busy), .op_count(op_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   valid;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [1:0]   id;
      logic [W:0]   sum;
   } vec_t;

   vec_t vt[8];

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fill_lanes(input logic [1:0] id, input logic [W-1:0] a,
                             input logic [W-1:0] b);
      logic [63:0] r;
      for (int i = 0; i < 4; i++) begin
         r = {$urandom(), $urandom()};
         req_a[i*W +: W] = (i == int'(id)) ? a : r[W-1:0];
         r = {$urandom(), $urandom()};
         req_b[i*W +: W] = (i == int'(id)) ? b : r[W-1:0];
      end
   endtask

   task automatic scramble;
      logic [63:0] r;
      for (int i = 0; i < 4; i++) begin
         r = {$urandom(), $urandom()};
         req_a[i*W +: W] = r[W-1:0];
         r = {$urandom(), $urandom()};
         req_b[i*W +: W] = r[W-1:0];
      end
   endtask

   // one complete operation with res_ready held high
   task automatic do_op(input logic [3:0] v, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [1:0] id,
                        input logic [W:0] sum);
      @(negedge clk);
      res_ready = 1'b1;
      req_valid = v;
      fill_lanes(id, a, b);
      #1;
      check("grant", 64'(req_ready), 64'(4'b0001 << id));
      check("idle_busy", 64'(busy), 64'd0);
      @(negedge clk);
      req_valid = 4'b0000;
      scramble();
      #1;
      check("calc_busy", 64'(busy), 64'd1);
      check("calc_ready", 64'(req_ready), 64'd0);
      check("calc_valid", 64'(res_valid), 64'd0);
      @(negedge clk);
      #1;
      check("res_valid", 64'(res_valid), 64'd1);
      check("res_sum", 64'(res_sum), 64'(sum));
      check("res_id", 64'(res_id), 64'(id));
      exp_cnt++;
      @(negedge clk);
      #1;
      check("post_valid", 64'(res_valid), 64'd0);
      check("post_busy", 64'(busy), 64'd0);
      check("op_count", 64'(op_count), 64'(exp_cnt));
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = 4'b1111;
      #1;
      check("rst_ready", 64'(req_ready), 64'd0);
      check("rst_valid", 64'(res_valid), 64'd0);
      check("rst_sum", 64'(res_sum), 64'd0);
      check("rst_id", 64'(res_id), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_count", 64'(op_count), 64'd0);
      exp_cnt = 0;
      @(negedge clk);
      req_valid = 4'b0000;
      rst_n = 1'b1;
   endtask

   initial begin
      int grants[5];
      int ng;
      logic [W:0] hold_sum;
      logic seen;

      rst_n = 1'b0;
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      res_ready = 1'b1;

      vt[0] = '{4'b0001, 57'd5, 57'd7, 2'd0, 58'd12};
      vt[1] = '{4'b1111, ONES, ONES, 2'd1, 58'h3FF_FFFF_FFFF_FFFE};
      vt[2] = '{4'b0011, 57'd1000, 57'd24, 2'd0, 58'd1024};
      vt[3] = '{4'b1000, 57'h1_0000_0000, 57'd3, 2'd3, 58'h1_0000_0003};
      vt[4] = '{4'b0110, 57'd100, 57'd23, 2'd1, 58'd123};
      vt[5] = '{4'b0100, 57'd0, 57'd0, 2'd2, 58'd0};
      vt[6] = '{4'b0101, 57'd77, 57'd1, 2'd0, 58'd78};
      vt[7] = '{4'b1010, ONES, 57'd1, 2'd1, 58'h200_0000_0000_0000};

      do_reset();
      for (int i = 0; i < 8; i++)
         do_op(vt[i].valid, vt[i].a, vt[i].b, vt[i].id, vt[i].sum);

      // round robin with all requesters pending
      do_reset();
      @(negedge clk);
      req_valid = 4'b1111;
      res_ready = 1'b1;
      scramble();
      ng = 0;
      for (int c = 0; c < 30 && ng < 5; c++) begin
         #1;
         if (req_ready != 4'b0000) begin
            check("rr_onehot", 64'($onehot(req_ready)), 64'd1);
            for (int j = 0; j < 4; j++)
               if (req_ready[j]) grants[ng] = j;
            ng++;
            if (ng == 5) req_valid = 4'b0000;
         end
         @(negedge clk);
      end
      check("rr_count", 64'(ng), 64'd5);
      for (int k = 0; k < 5; k++)
         check("rr_order", 64'(grants[k]), 64'(k % 4));
      exp_cnt = 4;
      repeat (3) @(negedge clk);
      #1;
      check("rr_opcount", 64'(op_count), 64'(exp_cnt));

      // backpressure in DONE
      @(negedge clk);
      res_ready = 1'b0;
      req_valid = 4'b0001;
      fill_lanes(2'd0, 57'd9, 57'd1);
      @(negedge clk);
      req_valid = 4'b0000;
      @(negedge clk);
      #1;
      check("bp_valid", 64'(res_valid), 64'd1);
      check("bp_sum", 64'(res_sum), 64'd10);
      check("bp_id", 64'(res_id), 64'd0);
      hold_sum = res_sum;
      req_valid = 4'b1111;
      scramble();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         #1;
         check("bp_hold_valid", 64'(res_valid), 64'd1);
         check("bp_hold_sum", 64'(res_sum), 64'(hold_sum));
         check("bp_hold_ready", 64'(req_ready), 64'd0);
      end
      res_ready = 1'b1;
      req_valid = 4'b0000;
      exp_cnt++;
      @(negedge clk);
      #1;
      check("bp_idle", 64'(busy), 64'd0);
      check("bp_release", 64'(res_valid), 64'd0);
      check("bp_opcount", 64'(op_count), 64'(exp_cnt));

      // reset while in CALC: rr_ptr is 1 here, must return to 0
      @(negedge clk);
      req_valid = 4'b0100;
      fill_lanes(2'd2, 57'd3, 57'd4);
      #1;
      check("mr_grant", 64'(req_ready), 64'b0100);
      @(negedge clk);
      #1;
      check("mr_calc", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mr_busy", 64'(busy), 64'd0);
      check("mr_valid", 64'(res_valid), 64'd0);
      check("mr_sum", 64'(res_sum), 64'd0);
      check("mr_id", 64'(res_id), 64'd0);
      check("mr_count", 64'(op_count), 64'd0);
      check("mr_ready", 64'(req_ready), 64'd0);
      exp_cnt = 0;
      @(negedge clk);
      req_valid = 4'b0000;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         #1;
         if (res_valid) seen = 1'b1;
      end
      check("mr_no_pulse", 64'(seen), 64'd0);
      do_op(4'b1111, 57'd40, 57'd2, 2'd0, 58'd42);
      do_op(4'b0100, 57'd8, 57'd8, 2'd2, 58'd16);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
